// File: rtl/uart_text_console_pkg.sv
// Shared character codes and controller state encoding for the UART text console.
package uart_text_console_pkg;

  localparam logic [7:0] CHAR_BS       = 8'h08;
  localparam logic [7:0] CHAR_TAB      = 8'h09;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] CHAR_FF       = 8'h0C;
  localparam logic [7:0] CHAR_CR       = 8'h0D;
  localparam logic [7:0] CHAR_CR_HI    = 8'h8D;
  localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_CLR_ALL = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CLR_ROW = 2'd2
  } state_e;

endpackage

// File: rtl/uart_text_console_clear_seq.sv
// Row/column walker for fill writes: visits rows row_first..row_last, cols 0..COLS-1,
// one cell per cycle while active; last flags the final cell.
module uart_text_console_clear_seq
  import uart_text_console_pkg::*;
#(
  parameter int COLS  = 80,
  parameter int COL_W = 7,
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ROW_W-1:0] row_first,
  input  logic [ROW_W-1:0] row_last,
  output logic             active,
  output logic             last,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic             active_q, active_d;
  logic [ROW_W-1:0] row_q, row_d, last_row_q, last_row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      row_q      <= '0;
      last_row_q <= '0;
      col_q      <= '0;
    end else begin
      active_q   <= active_d;
      row_q      <= row_d;
      last_row_q <= last_row_d;
      col_q      <= col_d;
    end
  end

  always_comb begin
    active_d   = active_q;
    row_d      = row_q;
    last_row_d = last_row_q;
    col_d      = col_q;
    if (start) begin
      active_d   = 1'b1;
      row_d      = row_first;
      last_row_d = row_last;
      col_d      = '0;
    end else if (active_q) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        if (row_q == last_row_q) active_d = 1'b0;
        else                     row_d    = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign active = active_q;
  assign last   = active_q && (col_q == COL_MAX) && (row_q == last_row_q);
  assign row    = row_q;
  assign col    = col_q;

endmodule

// File: rtl/uart_text_console.sv
// Terminal-style byte writer into the character VRAM: glyphs, cursor control,
// auto-wrap and hardware scroll with row clears.
module uart_text_console
  import uart_text_console_pkg::*;
#(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter int         COL_W     = 7,
  parameter int         ROW_W     = 5,
  parameter int         TAB_W     = 8,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   btn_rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [COL_W+ROW_W-1:0] vram_addr,
  output logic [7:0]             vram_data,
  output logic                   vram_we,
  output logic [COL_W-1:0]       cur_col,
  output logic [ROW_W-1:0]       cur_row,
  output logic [ROW_W-1:0]       scroll_row,
  output logic                   busy
);

  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]   ROWS_WIDE = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0]   TAB_MASK  = (COL_W + 1)'(TAB_W - 1);

  state_e                   state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d, scroll_q, scroll_d;
  logic                     we_q, we_d;
  logic [COL_W+ROW_W-1:0]   addr_q, addr_d;
  logic [7:0]               data_q, data_d;

  logic                     seq_start, seq_active, seq_last;
  logic [ROW_W-1:0]         seq_first_row, seq_last_row, seq_row;
  logic [COL_W-1:0]         seq_col;

  logic [ROW_W:0]           row_sum;
  logic [ROW_W-1:0]         phys_row;
  logic [COL_W:0]           tab_next;
  logic [COL_W-1:0]         tab_col;
  logic                     accept, is_print, newline;

  assign row_sum  = {1'b0, scroll_q} + {1'b0, row_q};
  assign phys_row = (row_sum >= ROWS_WIDE) ? ROW_W'(row_sum - ROWS_WIDE) : row_sum[ROW_W-1:0];
  assign tab_next = ({1'b0, col_q} | TAB_MASK) + 1'b1;
  assign tab_col  = (tab_next >= {1'b0, COL_MAX}) ? COL_MAX : tab_next[COL_W-1:0];

  assign accept   = rx_valid && (state_q == ST_IDLE);
  assign is_print = (rx_data >= CHAR_PRINT_LO) && (rx_data <= CHAR_PRINT_HI);
  assign newline  = accept && ((rx_data == CHAR_LF) || (is_print && col_q == COL_MAX));

  uart_text_console_clear_seq #(.COLS(COLS), .COL_W(COL_W), .ROW_W(ROW_W)) u_clear_seq (
    .clk       (clk),
    .rst_n     (btn_rst_n),
    .start     (seq_start),
    .row_first (seq_first_row),
    .row_last  (seq_last_row),
    .active    (seq_active),
    .last      (seq_last),
    .row       (seq_row),
    .col       (seq_col)
  );

  always_ff @(posedge clk) begin
    if (!btn_rst_n) begin
      state_q  <= ST_CLR_ALL;
      col_q    <= '0;
      row_q    <= '0;
      scroll_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      scroll_q <= scroll_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // A plain LF starts its row clear at once; a wrapping glyph defers it one cycle so
  // the glyph write goes out first. The deferred start sees the new scroll_row, so
  // phys_row of the bottom line is then the old top row.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    scroll_d      = scroll_q;
    seq_start     = 1'b0;
    seq_first_row = phys_row;
    seq_last_row  = phys_row;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_print) begin
            col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
          end else begin
            case (rx_data)
              CHAR_CR, CHAR_CR_HI: col_d = '0;
              CHAR_BS:             if (col_q != '0) col_d = col_q - 1'b1;
              CHAR_TAB:            col_d = tab_col;
              CHAR_FF: begin
                col_d         = '0;
                row_d         = '0;
                scroll_d      = '0;
                state_d       = ST_CLR_ALL;
                seq_start     = 1'b1;
                seq_first_row = '0;
                seq_last_row  = ROW_MAX;
              end
              default: ;
            endcase
          end
          if (newline) begin
            if (row_q != ROW_MAX) begin
              row_d = row_q + 1'b1;
            end else begin
              scroll_d = (scroll_q == ROW_MAX) ? '0 : scroll_q + 1'b1;
              state_d  = ST_CLR_ROW;
              if (!is_print) begin
                seq_start     = 1'b1;
                seq_first_row = scroll_q;
                seq_last_row  = scroll_q;
              end
            end
          end
        end
      end
      ST_CLR_ALL: begin
        seq_first_row = '0;
        seq_last_row  = ROW_MAX;
        if (!seq_active)   seq_start = 1'b1;
        else if (seq_last) state_d   = ST_IDLE;
      end
      ST_CLR_ROW: begin
        if (!seq_active)   seq_start = 1'b1;
        else if (seq_last) state_d   = ST_IDLE;
      end
      default: state_d = ST_CLR_ALL;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (accept && is_print) begin
      we_d   = 1'b1;
      addr_d = {phys_row, col_q};
      data_d = rx_data;
    end else if (accept && rx_data == CHAR_BS && col_q != '0) begin
      we_d   = 1'b1;
      addr_d = {phys_row, col_q - 1'b1};
      data_d = FILL_CHAR;
    end
  end

  assign vram_we    = seq_active | we_q;
  assign vram_addr  = seq_active ? {seq_row, seq_col} : addr_q;
  assign vram_data  = seq_active ? FILL_CHAR : data_q;
  assign rx_ready   = (state_q == ST_IDLE);
  assign busy       = ~rx_ready;
  assign cur_col    = col_q;
  assign cur_row    = row_q;
  assign scroll_row = scroll_q;

endmodule

// File: tb/tb_uart_text_console.sv
// Self-checking bench for uart_text_console: byte vectors table plus scoreboard of VRAM writes.
module tb_uart_text_console;

  logic        clk;
  logic        btn_rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic [4:0]  scroll_row;
  logic        busy;

  uart_text_console dut (
    .clk        (clk),
    .btn_rst_n  (btn_rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .vram_we    (vram_we),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .scroll_row (scroll_row),
    .busy       (busy)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    bit         we;
    int         wr;
    int         wc;
    logic [7:0] wd;
    int         col;
    int         row;
    int         scr;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[20];
  int   tests = 0;
  int   fails = 0;
  int   wr_cnt = 0;
  int   last_wr_cyc = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every visible write is checked against the head of the expected queue.
  always @(negedge clk) begin
    if (btn_rst_n && vram_we) begin
      exp_t e;
      wr_cnt++;
      last_wr_cyc = cyc;
      tests++;
      if (vram_addr[6:0] >= 7'd80) begin
        fails++;
        $display("FAIL write_col_range: got col %0d required < 80", vram_addr[6:0]);
      end
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%h data=%h required no write", vram_addr, vram_data);
      end else begin
        e = sb.pop_front();
        if (vram_addr !== e.addr || vram_data !== e.data) begin
          fails++;
          $display("FAIL write_%0d: got addr=%h data=%h required addr=%h data=%h",
                   wr_cnt, vram_addr, vram_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic push_wr(input int r, input int c, input logic [7:0] d);
    exp_t e;
    e.addr = {5'(r), 7'(c)};
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_clear(input int first, input int last);
    for (int r = first; r <= last; r++)
      for (int c = 0; c < 80; c++) push_wr(r, c, 8'h20);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rx_ready) return;
      n++;
    end
    tests++;
    fails++;
    $display("FAIL wait_ready: got no rx_ready within 3000 cycles required rx_ready=1");
  endtask

  task automatic send(input logic [7:0] b);
    int w;
    wait_ready(w);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic step(input logic [7:0] b, input bit we, input int wr, input int wc,
                      input logic [7:0] wd, input int ecol, input int erow, input int escr);
    if (we) push_wr(wr, wc, wd);
    send(b);
    @(negedge clk);
    #1;
    $display("[TB] byte %h -> col=%0d row=%0d scroll=%0d", b, cur_col, cur_row, scroll_row);
    chk("cur_col", int'(cur_col), ecol);
    chk("cur_row", int'(cur_row), erow);
    chk("scroll_row", int'(scroll_row), escr);
    chk("pending_writes", sb.size(), 0);
    chk("rx_ready_after", int'(rx_ready), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, low, base, rdy_cyc;
    tbl = '{
      '{8'h41, 1'b1, 0,  0, 8'h41,  1, 0, 0},
      '{8'h0D, 1'b0, 0,  0, 8'h00,  0, 0, 0},
      '{8'h0A, 1'b0, 0,  0, 8'h00,  0, 1, 0},
      '{8'h42, 1'b1, 1,  0, 8'h42,  1, 1, 0},
      '{8'h07, 1'b0, 0,  0, 8'h00,  1, 1, 0},
      '{8'hC1, 1'b0, 0,  0, 8'h00,  1, 1, 0},
      '{8'h8D, 1'b0, 0,  0, 8'h00,  0, 1, 0},
      '{8'h09, 1'b0, 0,  0, 8'h00,  8, 1, 0},
      '{8'h09, 1'b0, 0,  0, 8'h00, 16, 1, 0},
      '{8'h08, 1'b1, 1, 15, 8'h20, 15, 1, 0},
      '{8'h08, 1'b1, 1, 14, 8'h20, 14, 1, 0},
      '{8'h0D, 1'b0, 0,  0, 8'h00,  0, 1, 0},
      '{8'h08, 1'b0, 0,  0, 8'h00,  0, 1, 0},
      '{8'h7E, 1'b1, 1,  0, 8'h7E,  1, 1, 0},
      '{8'h20, 1'b1, 1,  1, 8'h20,  2, 1, 0},
      '{8'h1F, 1'b0, 0,  0, 8'h00,  2, 1, 0},
      '{8'h7F, 1'b0, 0,  0, 8'h00,  2, 1, 0},
      '{8'h0A, 1'b0, 0,  0, 8'h00,  2, 2, 0},
      '{8'h0A, 1'b0, 0,  0, 8'h00,  2, 3, 0},
      '{8'h0D, 1'b0, 0,  0, 8'h00,  0, 3, 0}
    };

    // Reset state and power-up clear
    btn_rst_n = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_vram_we", int'(vram_we), 0);
    chk("rst_vram_addr", int'(vram_addr), 0);
    chk("rst_vram_data", int'(vram_data), 0);
    chk("rst_cur_col", int'(cur_col), 0);
    chk("rst_cur_row", int'(cur_row), 0);
    chk("rst_scroll", int'(scroll_row), 0);
    chk("rst_rx_ready", int'(rx_ready), 0);
    chk("rst_busy", int'(busy), 1);
    push_clear(0, 29);
    base = wr_cnt;
    btn_rst_n = 1'b1;
    wait_ready(w);
    rdy_cyc = cyc;
    chk("init_clear_writes", wr_cnt - base, 2400);
    chk("init_ready_cycle", rdy_cyc, last_wr_cyc + 1);
    chk("init_pending", sb.size(), 0);

    // Single-byte vectors from home
    for (int i = 0; i < 20; i++)
      step(tbl[i].b, tbl[i].we, tbl[i].wr, tbl[i].wc, tbl[i].wd, tbl[i].col, tbl[i].row, tbl[i].scr);

    // Row 3: tabs to 72, saturating tab, backspace, then wrap at col 79
    for (int i = 1; i <= 9; i++) step(8'h09, 1'b0, 0, 0, 8'h00, 8 * i, 3, 0);
    step(8'h09, 1'b0, 0, 0, 8'h00, 79, 3, 0);
    step(8'h08, 1'b1, 3, 78, 8'h20, 78, 3, 0);
    step(8'h59, 1'b1, 3, 78, 8'h59, 79, 3, 0);
    step(8'h5A, 1'b1, 3, 79, 8'h5A, 0, 4, 0);

    // Row 4: backspace at col 5, tab from col 3
    for (int i = 0; i < 5; i++) step(8'(8'h61 + i), 1'b1, 4, i, 8'(8'h61 + i), i + 1, 4, 0);
    step(8'h08, 1'b1, 4, 4, 8'h20, 4, 4, 0);
    step(8'h0D, 1'b0, 0, 0, 8'h00, 0, 4, 0);
    for (int i = 0; i < 3; i++) step(8'(8'h66 + i), 1'b1, 4, i, 8'(8'h66 + i), i + 1, 4, 0);
    step(8'h09, 1'b0, 0, 0, 8'h00, 8, 4, 0);

    // Down to the bottom row
    for (int i = 0; i < 25; i++) step(8'h0A, 1'b0, 0, 0, 8'h00, 8, 5 + i, 0);

    // LF at bottom: scroll, 80-cycle row clear, held byte taken once afterwards
    push_clear(0, 0);
    push_wr(0, 8, 8'h51);
    wait_ready(w);
    rx_data  = 8'h0A;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_data = 8'h51;
    low = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_ready) break;
      low++;
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] scroll LF: ready low %0d cycles, scroll=%0d", low, scroll_row);
    chk("scroll_ready_low", low, 80);
    chk("scroll_scroll_row", int'(scroll_row), 1);
    chk("scroll_cur_row", int'(cur_row), 29);
    chk("scroll_held_col", int'(cur_col), 9);
    chk("scroll_pending", sb.size(), 0);

    // Wrap at bottom: glyph first, then clear of the old top row
    step(8'h0D, 1'b0, 0, 0, 8'h00, 0, 29, 1);
    for (int i = 1; i <= 10; i++) step(8'h09, 1'b0, 0, 0, 8'h00, (i == 10) ? 79 : 8 * i, 29, 1);
    push_wr(0, 79, 8'h57);
    push_clear(1, 1);
    send(8'h57);
    wait_ready(w);
    #1;
    $display("[TB] wrap at bottom: col=%0d row=%0d scroll=%0d", cur_col, cur_row, scroll_row);
    chk("wrapscroll_col", int'(cur_col), 0);
    chk("wrapscroll_row", int'(cur_row), 29);
    chk("wrapscroll_scroll", int'(scroll_row), 2);
    chk("wrapscroll_pending", sb.size(), 0);

    // Form feed after scrolling, with a reset pulse partway through the clear
    step(8'h50, 1'b1, 1, 0, 8'h50, 1, 29, 2);
    push_clear(0, 29);
    base = wr_cnt;
    send(8'h0C);
    @(negedge clk);
    #1;
    chk("ff_col", int'(cur_col), 0);
    chk("ff_row", int'(cur_row), 0);
    chk("ff_scroll", int'(scroll_row), 0);
    chk("ff_busy", int'(busy), 1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (wr_cnt - base >= 1000) break;
    end
    chk("ff_reached_1000", int'(wr_cnt - base >= 1000), 1);
    btn_rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    push_clear(0, 29);
    @(negedge clk);
    #1;
    chk("midrst_vram_we", int'(vram_we), 0);
    chk("midrst_vram_addr", int'(vram_addr), 0);
    chk("midrst_rx_ready", int'(rx_ready), 0);
    @(negedge clk);
    btn_rst_n = 1'b1;
    base = wr_cnt;
    wait_ready(w);
    #1;
    $display("[TB] restart clear: %0d writes", wr_cnt - base);
    chk("restart_writes", wr_cnt - base, 2400);
    chk("restart_pending", sb.size(), 0);
    chk("restart_col", int'(cur_col), 0);
    step(8'h43, 1'b1, 0, 0, 8'h43, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
